lc3_instr_encoder: RTL and testbench
====================================

Name: lc3_instr_encoder

Overview:
- Streaming LC-3 instruction encoder and loader, the inverse of the opcode/control decoder.
- Accepts opcode plus operand fields over a valid/ready handshake and packs them into 16-bit LC-3 instruction words.
- Writes the words to instruction memory at consecutive addresses. Used by the boot/test loader to build programs in memory.
- Rejects reserved opcodes and out-of-range immediates. Stops after a HALT instruction.

Parameters:
- ADDR_W, 16, memory address width.
- DEF_ADDR, 16'h3000, load address used when start_addr is zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; latches start_addr and enters RUN.
- start_addr  in  ADDR_W  first write address; 0 selects DEF_ADDR.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  4  LC-3 opcode [15:12].
- ra  in  3  DR/SR field; nzp for BR.
- rb  in  3  SR1/BaseR field.
- rc  in  3  SR2 field.
- imm_mode  in  1  ADD/AND immediate form; JSR (1) vs JSRR (0).
- imm  in  16  signed immediate/offset; unsigned trapvect for TRAP.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  encoded instruction.
- done  out  1  high in DONE.
- err  out  1  sticky; set on any rejected bundle, cleared by start or rst.
- err_code  out  2  last error: 01 reserved opcode, 10 immediate out of range.
- wr_count  out  16  instructions written since start.

Behaviour:
- Reset values: state IDLE; mem_we, done, err, in_ready all 0; err_code 0; wr_count 0; mem_addr DEF_ADDR; mem_wdata 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when a HALT bundle (opcode 1111, imm[7:0]=8'h25) is accepted.
  - DRAIN -> DONE when the pending write completes.
  - DONE -> RUN on start.
  - start in RUN or DRAIN is ignored.
- Entering RUN loads mem_addr from start_addr (DEF_ADDR if 0), clears wr_count and err.
- in_ready = (state==RUN) && (!mem_we || mem_ready).
- A bundle is accepted when in_valid && in_ready. The encoded word appears on mem_wdata with mem_we=1 on the next cycle (latency 1).
- mem_we, mem_addr and mem_wdata hold stable until mem_ready is high.
- Write completion is mem_we && mem_ready. On completion: mem_addr increments by 1, wrapping modulo 2^ADDR_W, and wr_count increments, saturating at FFFF.
- Back-to-back bundles: an acceptance in the same cycle as a completion loads the next word with no bubble, giving throughput of 1 per cycle.
- Encodings:
  - ADD 0001 / AND 0101: ra, rb, then imm_mode ? {1, imm[4:0]} : {000, rc}.
  - NOT 1001: ra, rb, 111111.
  - BR 0000: ra (nzp), imm[8:0].
  - LD 0010, LDI 1010, LEA 1110, ST 0011, STI 1011: ra, imm[8:0].
  - LDR 0110 / STR 0111: ra, rb, imm[5:0].
  - JMP/RET 1100: 000, rb, 000000.
  - JSR 0100: imm_mode ? {1, imm[10:0]} : {000, rb, 000000}.
  - RTI 1000: 1000_0000_0000_0000.
  - TRAP 1111: 0000, imm[7:0].
- Range checks (signed): imm5 -16..15, offset6 -32..31, PCoffset9 -256..255, PCoffset11 -1024..1023. For TRAP, imm[15:8] must be 0.
- Rejected bundle (opcode 1101, or range failure):
  - Still consumed; no write issued.
  - err=1 and err_code updated the cycle after acceptance.
  - Address and count unchanged.
  - A rejected HALT does not leave RUN.
- rst mid-operation: pending write is dropped (mem_we=0 next cycle) and all state returns to reset values.

Test Plan:
- rst, start with start_addr=0; ADD ra=1 rb=2 imm_mode=1 imm=-3 -> mem_addr 3000, mem_wdata 12BD one cycle later; wr_count 1.
- LDR ra=3 rb=4 imm=5, then BR ra=111 imm=-1, back-to-back with mem_ready=1 -> 6705 @3000 and 0FFF @3001 on consecutive cycles.
- Hold mem_ready=0 for 3 cycles with a second bundle pending -> in_ready=0, mem_wdata/mem_addr stable, no loss; after release both words are written in order.
- opcode 1101, then ADD imm_mode=1 imm=16 -> no writes, err=1, err_code=10 after the second, mem_addr unchanged; next start clears err.
- TRAP imm=0025 -> F025 written, state DRAIN then DONE, done=1, in_ready=0 with in_valid held; start with start_addr=4000 -> RUN, next word written at 4000.
- start_addr=FFFF, two ADD writes -> addresses FFFF then 0000; rst asserted while mem_we=1 and mem_ready=0 -> mem_we=0 and mem_addr=3000 next cycle.

Source files
------------

// File: rtl/lc3_instr_encoder.sv
// lc3_instr_encoder
// Streaming LC-3 instruction encoder and loader. Each operand bundle taken
// over the in_valid/in_ready handshake is packed into a 16-bit LC-3 word and
// written to instruction memory at consecutive addresses. Reserved opcodes and
// out-of-range immediates are consumed but not written. Loading stops once a
// HALT (TRAP x25) has been written.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start, start_addr  begin a load; start_addr of 0 selects DEF_ADDR
//   in_valid/in_ready  operand bundle handshake
//   opcode, ra, rb, rc operand fields (ra carries nzp for BR)
//   imm_mode, imm      immediate form select / signed immediate or trapvect
//   mem_we, mem_ready  write request and memory acceptance
//   mem_addr, mem_wdata write address and encoded instruction
//   done               load finished after HALT
//   err, err_code      sticky error flag and last error (01 opcode, 10 range)
//   wr_count           instructions written since start (saturating)
module lc3_instr_encoder #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  DEF_ADDR = 'h3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [2:0]        rc,
  input  logic              imm_mode,
  input  logic [15:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [15:0] enc_word;
  logic        enc_reserved;
  logic        enc_range_bad;
  logic        accept;
  logic        complete;
  logic        is_halt;

  // A signed immediate fits in N bits when every bit above bit N-2 equals
  // the sign bit, i.e. imm[15:N-1] is all zeros or all ones.
  always_comb begin
    enc_word      = 16'h0000;
    enc_reserved  = 1'b0;
    enc_range_bad = 1'b0;
    case (opcode)
      4'b0001, 4'b0101: begin
        if (imm_mode) begin
          enc_word      = {opcode, ra, rb, 1'b1, imm[4:0]};
          enc_range_bad = !((imm[15:4] == '0) || (imm[15:4] == '1));
        end else begin
          enc_word = {opcode, ra, rb, 3'b000, rc};
        end
      end
      4'b1001: enc_word = {opcode, ra, rb, 6'b111111};
      4'b0000, 4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011: begin
        enc_word      = {opcode, ra, imm[8:0]};
        enc_range_bad = !((imm[15:8] == '0) || (imm[15:8] == '1));
      end
      4'b0110, 4'b0111: begin
        enc_word      = {opcode, ra, rb, imm[5:0]};
        enc_range_bad = !((imm[15:5] == '0) || (imm[15:5] == '1));
      end
      4'b1100: enc_word = {opcode, 3'b000, rb, 6'b000000};
      4'b0100: begin
        if (imm_mode) begin
          enc_word      = {opcode, 1'b1, imm[10:0]};
          enc_range_bad = !((imm[15:10] == '0) || (imm[15:10] == '1));
        end else begin
          enc_word = {opcode, 3'b000, rb, 6'b000000};
        end
      end
      4'b1000: enc_word = 16'h8000;
      4'b1111: begin
        // The trap vector is unsigned, so the upper byte must be clear.
        enc_word      = {opcode, 4'b0000, imm[7:0]};
        enc_range_bad = (imm[15:8] != 8'h00);
      end
      4'b1101: enc_reserved = 1'b1;
      default: enc_word = 16'h0000;
    endcase
  end

  assign in_ready = (state_q == ST_RUN) && (!mem_we_q || mem_ready);
  assign accept   = in_valid && in_ready;
  assign complete = mem_we_q && mem_ready;
  assign is_halt  = (opcode == 4'b1111) && (imm[7:0] == 8'h25);

  // Write path first, then the state machine; the start load only happens in
  // IDLE/DONE where no write is pending, so the two never contend. A new word
  // accepted in the same cycle as a completion overrides the mem_we clear,
  // which is what gives back-to-back throughput.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    wr_count_d  = wr_count_q;

    if (complete) begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q + ADDR_ONE;
      wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
    end

    if (accept) begin
      if (enc_reserved) begin
        err_d      = 1'b1;
        err_code_d = 2'b01;
      end else if (enc_range_bad) begin
        err_d      = 1'b1;
        err_code_d = 2'b10;
      end else begin
        mem_we_d    = 1'b1;
        mem_wdata_d = enc_word;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          mem_addr_d = (start_addr == '0) ? DEF_ADDR : start_addr;
          wr_count_d = 16'h0000;
          err_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept && is_halt && !enc_reserved && !enc_range_bad) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (complete) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= DEF_ADDR;
      mem_wdata_q <= 16'h0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      wr_count_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_lc3_instr_encoder.sv
// tb_lc3_instr_encoder
// Directed bench for lc3_instr_encoder with hand-computed instruction words.
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point, away from the active edge.
module tb_lc3_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic        imm_mode;
  logic [15:0] imm;
  logic        mem_we;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_addr;
  logic [15:0] exp_count;

  lc3_instr_encoder #(.ADDR_W(16), .DEF_ADDR(16'h3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .imm_mode   (imm_mode),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic mode, input logic [15:0] iv);
    opcode   = op;
    ra       = a;
    rb       = b;
    rc       = c;
    imm_mode = mode;
    imm      = iv;
    in_valid = 1'b1;
  endtask

  // One accepted bundle with mem_ready high: word visible next cycle, then
  // the write completes and address/count advance.
  task automatic sendGood(input string tag, input logic [3:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] c, input logic mode,
                          input logic [15:0] iv, input logic [15:0] exp_word);
    applyStimulus(op, a, b, c, mode, iv);
    step();
    in_valid = 1'b0;
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_word));
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    step();
    exp_addr  = exp_addr + 16'd1;
    exp_count = exp_count + 16'd1;
    checkOutput({tag, "_cnt"}, 32'(wr_count), 32'(exp_count));
    checkOutput({tag, "_nxtaddr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  task automatic sendBad(input string tag, input logic [3:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c, input logic mode,
                         input logic [15:0] iv, input logic [1:0] exp_code);
    applyStimulus(op, a, b, c, mode, iv);
    step();
    in_valid = 1'b0;
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd1);
    checkOutput({tag, "_code"}, 32'(err_code), 32'(exp_code));
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    checkOutput({tag, "_cnt"}, 32'(wr_count), 32'(exp_count));
    checkOutput({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 16'h0000;
    in_valid   = 1'b0;
    opcode     = 4'h0;
    ra         = 3'd0;
    rb         = 3'd0;
    rc         = 3'd0;
    imm_mode   = 1'b0;
    imm        = 16'h0000;
    mem_ready  = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_code", 32'(err_code), 32'd0);
    checkOutput("rst_rdy", 32'(in_ready), 32'd0);
    checkOutput("rst_cnt", 32'(wr_count), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h3000);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    // Start with address 0 selects the default load address
    start = 1'b1;
    start_addr = 16'h0000;
    step();
    start = 1'b0;
    checkOutput("run_rdy", 32'(in_ready), 32'd1);
    checkOutput("run_addr", 32'(mem_addr), 32'h3000);
    exp_addr  = 16'h3000;
    exp_count = 16'h0000;
    mem_ready = 1'b1;
    sendGood("add_imm", 4'b0001, 3'd1, 3'd2, 3'd0, 1'b1, 16'hFFFD, 16'h12BD);

    // Back-to-back LDR then BR: no bubble between the two writes
    applyStimulus(4'b0110, 3'd3, 3'd4, 3'd0, 1'b0, 16'h0005);
    step();
    checkOutput("b2b_w0", 32'(mem_wdata), 32'h6705);
    checkOutput("b2b_a0", 32'(mem_addr), 32'(exp_addr));
    checkOutput("b2b_rdy", 32'(in_ready), 32'd1);
    applyStimulus(4'b0000, 3'b111, 3'd0, 3'd0, 1'b0, 16'hFFFF);
    step();
    in_valid = 1'b0;
    checkOutput("b2b_we1", 32'(mem_we), 32'd1);
    checkOutput("b2b_w1", 32'(mem_wdata), 32'h0FFF);
    checkOutput("b2b_a1", 32'(mem_addr), 32'(exp_addr + 16'd1));
    step();
    exp_addr  = exp_addr + 16'd2;
    exp_count = exp_count + 16'd2;
    checkOutput("b2b_cnt", 32'(wr_count), 32'(exp_count));
    checkOutput("b2b_we2", 32'(mem_we), 32'd0);

    // Backpressure: hold mem_ready low with a second bundle waiting
    mem_ready = 1'b0;
    applyStimulus(4'b1001, 3'd5, 3'd6, 3'd0, 1'b0, 16'h0000);
    step();
    applyStimulus(4'b0011, 3'd2, 3'd0, 3'd0, 1'b0, 16'h000A);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_rdy", 32'(in_ready), 32'd0);
      checkOutput("bp_wdata", 32'(mem_wdata), 32'h9BBF);
      checkOutput("bp_addr", 32'(mem_addr), 32'(exp_addr));
      checkOutput("bp_we", 32'(mem_we), 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("bp_rel_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_w1", 32'(mem_wdata), 32'h340A);
    checkOutput("bp_a1", 32'(mem_addr), 32'(exp_addr + 16'd1));
    checkOutput("bp_c1", 32'(wr_count), 32'(exp_count + 16'd1));
    step();
    exp_addr  = exp_addr + 16'd2;
    exp_count = exp_count + 16'd2;
    checkOutput("bp_cnt", 32'(wr_count), 32'(exp_count));

    // Rejections and immediate boundaries
    sendBad("rsv", 4'b1101, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b01);
    sendBad("add16", 4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0010, 2'b10);
    sendGood("add15", 4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'h000F, 16'h102F);
    sendGood("and_reg", 4'b0101, 3'd7, 3'd1, 3'd3, 1'b0, 16'h0000, 16'h5E43);
    sendGood("addm16", 4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFF0, 16'h1030);
    sendBad("addm17", 4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFEF, 2'b10);
    sendGood("ld_m256", 4'b0010, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFF00, 16'h2100);
    sendBad("ld_256", 4'b0010, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0100, 2'b10);
    sendGood("jsr_m1024", 4'b0100, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFC00, 16'h4C00);
    sendGood("jsrr", 4'b0100, 3'd0, 3'd3, 3'd0, 1'b0, 16'h0000, 16'h40C0);
    sendGood("ret", 4'b1100, 3'd0, 3'd7, 3'd0, 1'b0, 16'h0000, 16'hC1C0);
    sendGood("rti", 4'b1000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h8000);
    sendGood("str_m32", 4'b0111, 3'd1, 3'd2, 3'd0, 1'b0, 16'hFFE0, 16'h72A0);
    sendBad("str_32", 4'b0111, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0020, 2'b10);
    sendBad("halt_bad", 4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0125, 2'b10);
    sendBad("rsv2", 4'b1101, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b01);

    // HALT: drain the pending write, then DONE with in_valid still high
    mem_ready = 1'b0;
    applyStimulus(4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0025);
    step();
    checkOutput("halt_we", 32'(mem_we), 32'd1);
    checkOutput("halt_wdata", 32'(mem_wdata), 32'hF025);
    checkOutput("halt_addr", 32'(mem_addr), 32'(exp_addr));
    checkOutput("drain_rdy", 32'(in_ready), 32'd0);
    checkOutput("drain_done", 32'(done), 32'd0);
    step();
    checkOutput("drain_hold_done", 32'(done), 32'd0);
    checkOutput("drain_hold_we", 32'(mem_we), 32'd1);
    mem_ready = 1'b1;
    step();
    exp_count = exp_count + 16'd1;
    checkOutput("done_done", 32'(done), 32'd1);
    checkOutput("done_we", 32'(mem_we), 32'd0);
    checkOutput("done_rdy", 32'(in_ready), 32'd0);
    checkOutput("done_cnt", 32'(wr_count), 32'(exp_count));
    step();
    checkOutput("done_stay", 32'(done), 32'd1);
    checkOutput("done_rdy2", 32'(in_ready), 32'd0);
    checkOutput("done_we2", 32'(mem_we), 32'd0);
    checkOutput("done_cnt2", 32'(wr_count), 32'(exp_count));
    checkOutput("done_err", 32'(err), 32'd1);

    // Restart from DONE at 4000 clears err and the count
    in_valid   = 1'b0;
    start      = 1'b1;
    start_addr = 16'h4000;
    step();
    start = 1'b0;
    checkOutput("re_err", 32'(err), 32'd0);
    checkOutput("re_cnt", 32'(wr_count), 32'd0);
    checkOutput("re_done", 32'(done), 32'd0);
    checkOutput("re_addr", 32'(mem_addr), 32'h4000);
    checkOutput("re_rdy", 32'(in_ready), 32'd1);
    exp_addr  = 16'h4000;
    exp_count = 16'h0000;
    sendGood("re_add", 4'b0001, 3'd1, 3'd2, 3'd0, 1'b1, 16'hFFFD, 16'h12BD);

    // Address wrap from FFFF to 0000
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst2_addr", 32'(mem_addr), 32'h3000);
    checkOutput("rst2_rdy", 32'(in_ready), 32'd0);
    start      = 1'b1;
    start_addr = 16'hFFFF;
    step();
    start = 1'b0;
    exp_addr  = 16'hFFFF;
    exp_count = 16'h0000;
    sendGood("wrap0", 4'b0001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 16'h1283);
    sendGood("wrap1", 4'b0101, 3'd2, 3'd2, 3'd0, 1'b1, 16'h0001, 16'h54A1);

    // Reset while a write is stalled drops it
    mem_ready = 1'b0;
    applyStimulus(4'b1001, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    step();
    in_valid = 1'b0;
    checkOutput("stall_we", 32'(mem_we), 32'd1);
    checkOutput("stall_wdata", 32'(mem_wdata), 32'h903F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("drop_we", 32'(mem_we), 32'd0);
    checkOutput("drop_addr", 32'(mem_addr), 32'h3000);
    checkOutput("drop_cnt", 32'(wr_count), 32'd0);
    checkOutput("drop_rdy", 32'(in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
